subleq_datapath: RTL and testbench

Operand and memory-access engine for the SUBLEQ CPU: it consumes the one-hot status strobes from the status sequencer and executes one `subleq A,B,C` instruction per pass. The instruction semantics are: mem[B] ← mem[B] − mem[A]; if the result ≤ 0, branch to C, else PC += 3. It owns the PC, the operand and data registers, the subtractor and the single-port memory interface.

---
 rtl/subleq_datapath.sv | 126 ++++++++++++
 tb/tb_subleq_datapath.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_datapath.sv
// rtl/subleq_datapath.sv - SUBLEQ operand/memory-access engine driven by one-hot status strobes
// Optional sticky halt on negative branch target: define SUBLEQ_HALT_EN.
module subleq_datapath #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 12,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s00_idle,
    input  logic              s01_rop0,
    input  logic              s02_rop1,
    input  logic              s03_rop2,
    input  logic              s04_rmd0,
    input  logic              s05_rmd1,
    input  logic              s06_exec,
    input  logic              s07_wbmd,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
`ifdef SUBLEQ_HALT_EN
    output logic              halt,
`endif
    output logic [AWIDTH-1:0] pc
);

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] opa_q, opa_d;
    logic [AWIDTH-1:0] opb_q, opb_d;
    logic [DWIDTH-1:0] opc_q, opc_d;
    logic [DWIDTH-1:0] mda_q, mda_d;
    logic [DWIDTH-1:0] res_q, res_d;
    logic              halted;

    logic [7:0] stb_raw;
    logic [7:0] stb_act;
    logic [7:0] stb_one;
    logic       res_le0;

`ifdef SUBLEQ_HALT_EN
    logic halt_q, halt_d;
    assign halted = halt_q;
    assign halt   = halt_q;
`else
    assign halted = 1'b0;
`endif

    assign stb_raw = {s07_wbmd, s06_exec, s05_rmd1, s04_rmd0,
                      s03_rop2, s02_rop1, s01_rop0, s00_idle};
    assign stb_act = halted ? 8'h00 : stb_raw;
    // Isolate the lowest set strobe so an illegal multi-hot input behaves as its lowest member.
    assign stb_one = stb_act & (~stb_act + 8'd1);

    assign res_le0   = res_q[DWIDTH-1] | (res_q == '0);
    assign mem_wdata = res_q;
    assign pc        = pc_q;

    logic unused_bits;
    assign unused_bits = ^{stb_one[0], stb_one[6], opc_q[DWIDTH-1:AWIDTH]};

    always_comb begin
        mem_rd   = |stb_one[5:1];
        mem_wr   = stb_one[7];
        mem_addr = '0;
        if (stb_one[1])      mem_addr = pc_q;
        else if (stb_one[2]) mem_addr = pc_q + AWIDTH'(1);
        else if (stb_one[3]) mem_addr = pc_q + AWIDTH'(2);
        else if (stb_one[4]) mem_addr = opa_q;
        else if (stb_one[5]) mem_addr = opb_q;
        else if (stb_one[7]) mem_addr = opb_q;
    end

    always_comb begin
        pc_d  = pc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        opc_d = opc_q;
        mda_d = mda_q;
        res_d = res_q;
`ifdef SUBLEQ_HALT_EN
        halt_d = halt_q;
`endif
        if (stb_one[2]) opa_d = mem_rdata[AWIDTH-1:0];
        if (stb_one[3]) opb_d = mem_rdata[AWIDTH-1:0];
        if (stb_one[4]) opc_d = mem_rdata;
        if (stb_one[5]) mda_d = mem_rdata;
        if (stb_one[6]) res_d = mem_rdata - mda_q;
        if (stb_one[7]) begin
`ifdef SUBLEQ_HALT_EN
            if (res_le0 && opc_q[DWIDTH-1]) halt_d = 1'b1;
            else if (res_le0)               pc_d   = opc_q[AWIDTH-1:0];
            else                            pc_d   = pc_q + AWIDTH'(3);
`else
            if (res_le0) pc_d = opc_q[AWIDTH-1:0];
            else         pc_d = pc_q + AWIDTH'(3);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= AWIDTH'(START_ADDR);
            opa_q <= '0;
            opb_q <= '0;
            opc_q <= '0;
            mda_q <= '0;
            res_q <= '0;
`ifdef SUBLEQ_HALT_EN
            halt_q <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            opc_q <= opc_d;
            mda_q <= mda_d;
            res_q <= res_d;
`ifdef SUBLEQ_HALT_EN
            halt_q <= halt_d;
`endif
        end
    end

endmodule

// File: tb/tb_subleq_datapath.sv
// tb/tb_subleq_datapath.sv - randomized check of subleq_datapath against an instruction-level model
module tb_subleq_datapath;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    stb;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] pc;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef SUBLEQ_HALT_EN
    logic          halt;
`endif

    logic [DW-1:0] tb_mem  [0:4095];
    logic [DW-1:0] ref_mem [0:4095];
    logic [AW-1:0] m_pc;
    logic          m_halt;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    subleq_datapath dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s00_idle  (stb[0]),
        .s01_rop0  (stb[1]),
        .s02_rop1  (stb[2]),
        .s03_rop2  (stb[3]),
        .s04_rmd0  (stb[4]),
        .s05_rmd1  (stb[5]),
        .s06_exec  (stb[6]),
        .s07_wbmd  (stb[7]),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef SUBLEQ_HALT_EN
        .halt      (halt),
`endif
        .pc        (pc)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= tb_mem[mem_addr];
        if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe k, occasionally with extra higher-numbered strobes that must lose.
    task automatic drive(input int k);
        int hi;
        hi  = 'hFF & ~((1 << (k + 1)) - 1);
        stb = 8'(1 << k);
        if ($urandom_range(3) == 0) stb = stb | 8'($urandom & hi);
    endtask

    task automatic put(input int a, input logic [DW-1:0] v);
        tb_mem[a]  = v;
        ref_mem[a] = v;
    endtask

    task automatic idle_cycle();
        if ($urandom_range(1) == 0) stb = 8'h00;
        else drive(0);
        #1;
        chk("idle_rd", {31'd0, mem_rd}, 0);
        chk("idle_wr", {31'd0, mem_wr}, 0);
        chk("idle_addr", {20'd0, mem_addr}, 0);
        @(posedge clk); #1;
        chk("idle_pc", {20'd0, pc}, {20'd0, m_pc});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stb   = 8'h00;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_pc   = '0;
        m_halt = 1'b0;
        chk("rst_pc", {20'd0, pc}, 0);
        chk("rst_res", {16'd0, mem_wdata}, 0);
`ifdef SUBLEQ_HALT_EN
        chk("rst_halt", {31'd0, halt}, 0);
`endif
    endtask

    task automatic run_instr();
        logic [AW-1:0] p, p1, p2, aa, wa;
        logic [AW-1:0] ea [1:7];
        logic [DW-1:0] cw, res;
        logic          le0;
        if (m_halt) begin
            for (int k = 1; k <= 7; k++) begin
                drive(k); #1;
                chk("halt_rd", {31'd0, mem_rd}, 0);
                chk("halt_wr", {31'd0, mem_wr}, 0);
                @(posedge clk); #1;
            end
            stb = 8'h00;
            chk("halt_pc", {20'd0, pc}, {20'd0, m_pc});
            return;
        end
        p   = m_pc;
        p1  = p + 1;
        p2  = p + 2;
        aa  = ref_mem[p][AW-1:0];
        wa  = ref_mem[p1][AW-1:0];
        cw  = ref_mem[p2];
        res = ref_mem[wa] - ref_mem[aa];
        ea[1] = p;  ea[2] = p1; ea[3] = p2; ea[4] = aa;
        ea[5] = wa; ea[6] = '0; ea[7] = wa;
        for (int k = 1; k <= 7; k++) begin
            drive(k); #1;
            chk($sformatf("rd%0d", k), {31'd0, mem_rd}, {31'd0, k <= 5});
            chk($sformatf("wr%0d", k), {31'd0, mem_wr}, {31'd0, k == 7});
            chk($sformatf("addr%0d", k), {20'd0, mem_addr}, {20'd0, ea[k]});
            if (k == 7) chk("wdata", {16'd0, mem_wdata}, {16'd0, res});
            @(posedge clk); #1;
        end
        stb = 8'h00;
        ref_mem[wa] = res;
        le0 = res[DW-1] || (res == 0);
`ifdef SUBLEQ_HALT_EN
        if (le0 && cw[DW-1]) m_halt = 1'b1;
        else if (le0)        m_pc   = cw[AW-1:0];
        else                 m_pc   = p + 3;
        chk("halt", {31'd0, halt}, {31'd0, m_halt});
`else
        if (le0) m_pc = cw[AW-1:0];
        else     m_pc = p + 3;
`endif
        chk("pc", {20'd0, pc}, {20'd0, m_pc});
    endtask

    task automatic reset_mid();
        for (int k = 1; k <= 4; k++) begin
            drive(k); #1;
            chk("mid_rd", {31'd0, mem_rd}, 1);
            @(posedge clk); #1;
        end
        drive(5);
        rst_n = 1'b0;
        #1;
        chk("mid_wr", {31'd0, mem_wr}, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        stb    = 8'h00;
        m_pc   = '0;
        m_halt = 1'b0;
        #1;
        chk("mid_pc", {20'd0, pc}, 0);
        chk("mid_res", {16'd0, mem_wdata}, 0);
        chk("mid_wr2", {31'd0, mem_wr}, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        stb       = 8'h00;
        mem_rdata = '0;
        m_pc      = '0;
        m_halt    = 1'b0;
        for (int i = 0; i < 4096; i++) put(i, '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("init_pc", {20'd0, pc}, 0);
        chk("init_rd", {31'd0, mem_rd}, 0);
        chk("init_wr", {31'd0, mem_wr}, 0);
        chk("init_addr", {20'd0, mem_addr}, 0);
        chk("init_res", {16'd0, mem_wdata}, 0);

        put(0, 10); put(1, 11); put(2, 6); put(10, 3); put(11, 5);
        run_instr();
        chk("t1_pc", {20'd0, pc}, 3);
        chk("t1_mem", {16'd0, tb_mem[11]}, 2);

        put(3, 10); put(4, 11); put(5, 6); put(10, 5); put(11, 5);
        run_instr();
        chk("t2_pc", {20'd0, pc}, 6);
        chk("t2_mem", {16'd0, tb_mem[11]}, 0);

        put(6, 20); put(7, 21); put(8, 16'h0FFE); put(20, 1); put(21, 1);
        run_instr();
        chk("t3a_pc", {20'd0, pc}, 32'hFFE);
        put(12'hFFE, 30); put(12'hFFF, 31); put(0, 16'h0020); put(30, 1); put(31, 0);
        run_instr();
        chk("t3_pc", {20'd0, pc}, 32'h020);
        chk("t3_mem", {16'd0, tb_mem[31]}, 32'hFFFF);

        put(32, 40); put(33, 41); put(34, 16'h0100); put(40, 1); put(41, 16'h8000);
        run_instr();
        chk("t4_pc", {20'd0, pc}, 32'h023);
        chk("t4_mem", {16'd0, tb_mem[41]}, 32'h7FFF);

        put(35, 50); put(36, 51); put(37, 16'hFFFF); put(50, 1); put(51, 1);
        run_instr();
        chk("t5_mem", {16'd0, tb_mem[51]}, 0);
`ifdef SUBLEQ_HALT_EN
        chk("t5_pc", {20'd0, pc}, 32'h023);
        chk("t5_halt", {31'd0, halt}, 1);
        run_instr();
        idle_cycle();
        do_reset();
`else
        chk("t5_pc", {20'd0, pc}, 32'hFFF);
`endif

        reset_mid();
        run_instr();

        for (int i = 0; i < 4096; i++) put(i, DW'($urandom));
        do_reset();
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(2)) idle_cycle();
            run_instr();
            if (m_halt) begin
                run_instr();
                do_reset();
            end
            if (n % 40 == 39) reset_mid();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
